mc_controller: RTL

Multi-cycle control unit for the RV32IM core. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. It receives opcode, funct3 and funct7 from the instruction decoder and drives the enables and selects for PC, instruction register, ALU, register file, memory port and the multiply/divide unit. It also counts retired instructions.

---
 rtl/rv_pkg.sv | 49 ++++
 rtl/mc_controller_if.sv | 46 ++++
 rtl/alu_op_decode.sv | 25 ++
 rtl/mc_controller.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32IM control unit.
// Contents: controller state enum, base opcode constants, ALU function
// codes, write-back and PC source select codes, and a legal-opcode helper.
package rv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_MD_WAIT,
        ST_TRAP
    } ctrl_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_MD  = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
            default:                            is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory signal bundle.
// master: the control unit (takes decode fields and handshakes, drives
//         enables, selects, illegal flag and retired-instruction count).
// slave:  the datapath/memory side.
interface mc_controller_if #(
    parameter int XLEN     = 32,
    parameter int OP_W     = 7,
    parameter int FUNCT3_W = 3,
    parameter int FUNCT7_W = 7
);
    logic [OP_W-1:0]     opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic                br_taken;
    logic                mem_ready;
    logic                md_done;

    logic                mem_req;
    logic                mem_we;
    logic                mem_addr_sel;
    logic                ir_we;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic                alu_a_sel;
    logic                alu_b_sel;
    logic [3:0]          alu_op;
    logic                reg_we;
    logic [1:0]          wb_sel;
    logic                md_start;
    logic                illegal;
    logic [XLEN-1:0]     instret;

    modport master (
        input  opcode, funct3, funct7, br_taken, mem_ready, md_done,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
               alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, md_start,
               illegal, instret
    );

    modport slave (
        output opcode, funct3, funct7, br_taken, mem_ready, md_done,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
               alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, md_start,
               illegal, instret
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct3/funct7[5] -> ALU function code.
// Ports: opcode, funct3, funct7_b5 (funct7 bit 5) in; alu_op out.
module alu_op_decode
    import rv_pkg::*;
#(
    parameter int OP_W     = 7,
    parameter int FUNCT3_W = 3
) (
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                funct7_b5,
    output logic [3:0]          alu_op
);
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_R:      alu_op = {funct7_b5, funct3};
            // Upper immediate bits only select arithmetic shift for SRAI.
            OP_IMM:    alu_op = {(funct3 == 3'b101) & funct7_b5, funct3};
            OP_LUI:    alu_op = ALU_PASS_B;
            OP_BRANCH: alu_op = ALU_SUB;
            default:   alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control unit: walks one instruction at a time through
// fetch, decode, execute, memory and write-back, and counts retirements.
// Ports: clock, reset (async, active-high), bus (mc_controller_if.master).
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_FETCH   | instruction read, waits for mem_ready, then latches IR
// ST_DECODE  | captures decode fields, picks EXEC or TRAP
// ST_EXEC    | ALU step; branches/JAL/JALR write PC; M-ops start MD unit
// ST_MEM     | data access for LOAD/STORE, waits for mem_ready
// ST_WB      | register write, PC += 4 unless a jump already wrote it
// ST_MD_WAIT | waits for md_done
// ST_TRAP    | illegal opcode; everything idle until reset
module mc_controller
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int OP_W     = 7,
    parameter int FUNCT3_W = 3,
    parameter int FUNCT7_W = 7
) (
    input  logic     clock,
    input  logic     reset,
    mc_controller_if.master bus
);
    ctrl_state_t         state;
    logic [OP_W-1:0]     op_q;
    logic [FUNCT3_W-1:0] f3_q;
    logic [FUNCT7_W-1:0] f7_q;
    logic [XLEN-1:0]     instret_q;

    logic is_r, is_imm, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_lui, is_auipc, is_md, is_jump;
    logic retire;

    assign is_r      = (op_q == OP_R);
    assign is_imm    = (op_q == OP_IMM);
    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);
    assign is_branch = (op_q == OP_BRANCH);
    assign is_jal    = (op_q == OP_JAL);
    assign is_jalr   = (op_q == OP_JALR);
    assign is_lui    = (op_q == OP_LUI);
    assign is_auipc  = (op_q == OP_AUIPC);
    assign is_jump   = is_jal | is_jalr;
    assign is_md     = is_r && (f7_q == FUNCT7_MULDIV);

    assign retire = ((state == ST_EXEC) && is_branch)
                  || ((state == ST_MEM) && is_store && bus.mem_ready)
                  || (state == ST_WB);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_FETCH;
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= '0;
            instret_q <= '0;
        end else begin
            if (retire)
                instret_q <= instret_q + XLEN'(1);
            case (state)
                ST_FETCH:   if (bus.mem_ready) state <= ST_DECODE;
                ST_DECODE: begin
                    op_q  <= bus.opcode;
                    f3_q  <= bus.funct3;
                    f7_q  <= bus.funct7;
                    state <= is_legal_op(bus.opcode) ? ST_EXEC : ST_TRAP;
                end
                ST_EXEC: begin
                    if (is_branch)             state <= ST_FETCH;
                    else if (is_load | is_store) state <= ST_MEM;
                    else if (is_md)            state <= ST_MD_WAIT;
                    else                       state <= ST_WB;
                end
                ST_MEM:     if (bus.mem_ready) state <= is_load ? ST_WB : ST_FETCH;
                ST_MD_WAIT: if (bus.md_done) state <= ST_WB;
                ST_WB:      state <= ST_FETCH;
                ST_TRAP:    state <= ST_TRAP;
                default:    state <= ST_FETCH;
            endcase
        end
    end

    alu_op_decode #(.OP_W(OP_W), .FUNCT3_W(FUNCT3_W)) u_alu_op_decode (
        .opcode    (op_q),
        .funct3    (f3_q),
        .funct7_b5 (f7_q[5]),
        .alu_op    (bus.alu_op)
    );

    // Operand/write-back selects follow the captured opcode; op_q clears on
    // reset and illegal opcodes match nothing, so these idle at zero.
    assign bus.alu_a_sel = is_auipc | is_jal;
    assign bus.alu_b_sel = is_imm | is_load | is_store | is_lui | is_auipc | is_jump;
    assign bus.wb_sel    = is_load ? WB_MEM : is_jump ? WB_PC4 : is_md ? WB_MD : WB_ALU;
    assign bus.illegal   = (state == ST_TRAP);
    assign bus.instret   = instret_q;

    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_src       = PC_PLUS4;
        bus.reg_we       = 1'b0;
        bus.md_start     = 1'b0;
        case (state)
            ST_FETCH: begin
                // Reset parks the FSM in FETCH; keep the bus quiet until release.
                bus.mem_req = ~reset;
                bus.ir_we   = bus.mem_ready & ~reset;
            end
            ST_EXEC: begin
                bus.md_start = is_md;
                if (is_branch) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_src = bus.br_taken ? PC_TARGET : PC_PLUS4;
                end else if (is_jal) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_src = PC_TARGET;
                end else if (is_jalr) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_src = PC_JALR;
                end
            end
            ST_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = is_store;
                bus.pc_we        = is_store & bus.mem_ready;
            end
            ST_WB: begin
                bus.reg_we = 1'b1;
                bus.pc_we  = ~is_jump;
            end
            default: ;
        endcase
    end
endmodule
